// File: rtl/alu_seq_pkg.sv
// ----------------------------------------------------------------------------
// alu_seq_pkg
// Shared types and constants for the round-robin ALU sequencer.
//   seq_state_t : sequencer FSM states (IDLE -> EXEC -> RESP -> IDLE)
//   OP_*        : 2-bit ALU opcodes as presented on ReqControl / AluControl
//   FLG_*       : bit positions inside the 4-bit NZCV flag vector
// ----------------------------------------------------------------------------
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } seq_state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int unsigned FLG_N = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Stateless round-robin priority search: picks the first asserted request at
// or after ptr_i, wrapping modulo NReq. The pointer register lives in the
// parent so that it only advances when a grant is actually taken.
// Ports:
//   req_i     in  NReq  request vector
//   ptr_i     in  IdW   index with highest priority this cycle
//   gnt_o     out NReq  one-hot grant (zero when no request)
//   gnt_idx_o out IdW   index of the granted request (0 when none)
//   any_o     out 1     at least one request asserted
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int unsigned NReq = 4,
    localparam int unsigned IdW  = $clog2(NReq)
) (
    input  logic [NReq-1:0] req_i,
    input  logic [IdW-1:0]  ptr_i,
    output logic [NReq-1:0] gnt_o,
    output logic [IdW-1:0]  gnt_idx_o,
    output logic            any_o
);

    logic [IdW-1:0] cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        cand      = '0;
        // Walk outward from the pointer; the first hit wins.
        for (int unsigned i = 0; i < NReq; i++) begin
            cand = IdW'((32'(ptr_i) + i) % NReq);
            if (!any_o && req_i[cand]) begin
                gnt_idx_o = cand;
                any_o     = 1'b1;
            end
        end
        gnt_o[gnt_idx_o] = any_o;
    end

endmodule

// File: rtl/alu_rr_sequencer.sv
// ----------------------------------------------------------------------------
// alu_rr_sequencer
// Shares one external combinational ALU between NReq requesters. A round-robin
// arbiter accepts one request in IDLE, the operands are registered and drive
// the ALU during EXEC, and the captured result/flags are returned tagged with
// the requester id through a valid/ready response port (RESP).
//
// Optional build macro: ALU_STICKY_FLAGS_EN adds StickyClr/StickyFlags, which
// accumulate carry/overflow seen across captures until cleared.
//
// Ports:
//   Clk, nRst             clock (rising edge), async active-low reset
//   ReqValid/ReqReady     per-requester handshake; ReqReady one-hot or zero
//   ReqA/ReqB             packed operands, requester i at [i*Bits +: Bits]
//   ReqControl            packed opcodes, requester i at [i*2 +: 2]
//   AluInA/AluInB/AluControl  registered drive to the shared ALU
//   AluResult/AluFlags    ALU outputs, flags as [3]N [2]Z [1]C [0]V
//   RspValid/RspReady     response handshake
//   RspId/RspResult/RspFlags  response payload, stable while RspValid
//   StickyClr/StickyFlags (ALU_STICKY_FLAGS_EN only) [1] carry, [0] overflow
// ----------------------------------------------------------------------------
module alu_rr_sequencer
    import alu_seq_pkg::*;
#(
    parameter  int unsigned Bits = 5,
    parameter  int unsigned NReq = 4,
    localparam int unsigned IdW  = $clog2(NReq)
) (
    input  logic                 Clk,
    input  logic                 nRst,
    input  logic [NReq-1:0]      ReqValid,
    output logic [NReq-1:0]      ReqReady,
    input  logic [NReq*Bits-1:0] ReqA,
    input  logic [NReq*Bits-1:0] ReqB,
    input  logic [NReq*2-1:0]    ReqControl,
    output logic [Bits-1:0]      AluInA,
    output logic [Bits-1:0]      AluInB,
    output logic [1:0]           AluControl,
    input  logic [Bits-1:0]      AluResult,
    input  logic [3:0]           AluFlags,
    output logic                 RspValid,
    input  logic                 RspReady,
    output logic [IdW-1:0]       RspId,
    output logic [Bits-1:0]      RspResult,
    output logic [3:0]           RspFlags
`ifdef ALU_STICKY_FLAGS_EN
    ,
    input  logic                 StickyClr,
    output logic [1:0]           StickyFlags
`endif
);

    seq_state_t      state_q, state_d;
    logic [IdW-1:0]  ptr_q,   ptr_d;
    logic [IdW-1:0]  id_q,    id_d;
    logic [Bits-1:0] a_q,     a_d;
    logic [Bits-1:0] b_q,     b_d;
    logic [1:0]      op_q,    op_d;
    logic [Bits-1:0] res_q,   res_d;
    logic [3:0]      flg_q,   flg_d;

    logic [NReq-1:0] arb_gnt;
    logic [IdW-1:0]  arb_idx;
    logic            arb_any;

    rr_arbiter #(
        .NReq (NReq)
    ) u_arb (
        .req_i     (ReqValid),
        .ptr_i     (ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        res_d    = res_q;
        flg_d    = flg_q;
        ReqReady = '0;

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    // Gated by nRst so ReqReady reads 0 while reset is held.
                    ReqReady = nRst ? arb_gnt : '0;
                    a_d      = ReqA[arb_idx*Bits +: Bits];
                    b_d      = ReqB[arb_idx*Bits +: Bits];
                    op_d     = ReqControl[arb_idx*2 +: 2];
                    id_d     = arb_idx;
                    ptr_d    = (32'(arb_idx) == NReq - 1) ? '0 : arb_idx + IdW'(1);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                res_d   = AluResult;
                flg_d   = AluFlags;
                state_d = RESP;
            end
            RESP: begin
                if (RspReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    // Operand registers keep driving the ALU outside EXEC; nothing is cleared.
    assign AluInA     = a_q;
    assign AluInB     = b_q;
    assign AluControl = op_q;

    assign RspValid  = (state_q == RESP);
    assign RspId     = id_q;
    assign RspResult = res_q;
    assign RspFlags  = flg_q;

`ifdef ALU_STICKY_FLAGS_EN
    logic [1:0] sticky_q, sticky_d;

    // Clear has priority over a same-cycle capture.
    always_comb begin
        sticky_d = sticky_q;
        if (StickyClr) begin
            sticky_d = '0;
        end else if (state_q == EXEC) begin
            sticky_d = sticky_q | {AluFlags[FLG_C], AluFlags[FLG_V]};
        end
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign StickyFlags = sticky_q;
`else
    // Sticky carry/overflow tracking is not built in this configuration.
`endif

endmodule
